// File: rtl/poly_compress.sv
// poly_compress: per-coefficient normalize + Kyber Compress_D, then little-endian 32-bit word packing.
// Defining POLY_COMPRESS_CHK_EN builds the rotating-XOR output checksum on chk.

module poly_compress #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned D     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             start,
    input  logic [15:0]      comp_din_1,
    input  logic [15:0]      comp_din_2,
    input  logic [DEPTH-1:0] in_index,
    input  logic             valid_in,
    output logic [31:0]      dout,
    output logic [DEPTH-1:0] dout_index,
    output logic             dout_valid,
    output logic             err,
    output logic [31:0]      chk,
    output logic             done
);

    localparam int unsigned HALF_Q   = 1664;
    localparam int unsigned NPAIRS   = 1 << (DEPTH - 1);
    localparam int unsigned WORDS    = ((1 << DEPTH) * D + 31) / 32;
    localparam int unsigned BUF_W    = 32 + 2 * 11;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned NUM_W    = 23;
    localparam int unsigned PROD_W   = 47;
    localparam int unsigned RECIP_SH = 35;
    localparam logic [23:0] RECIP    = 24'd10321340;
    localparam logic signed [16:0] Q_S = 17'sd3329;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DEPTH-1:0] in_cnt;
    logic [DEPTH-1:0] pk_cnt;
    logic [DEPTH-1:0] word_cnt;
    logic             s1_v, s2_v;
    logic [11:0]      s1_x1, s1_x2;
    logic [D-1:0]     s2_c1, s2_c2;
    logic [BUF_W-1:0] buf_q;
    logic [CNT_W-1:0] bit_cnt;

    logic             accept_c;
    logic [DEPTH-1:0] exp_idx_c;
    logic [2*D-1:0]   pair_c;
    logic [BUF_W-1:0] merged_c;
    logic [BUF_W-1:0] buf_nxt_c;
    logic [CNT_W-1:0] total_c;
    logic [CNT_W-1:0] cnt_nxt_c;
    logic             tail_c;
    logic             emit_c;
    logic [31:0]      word_c;

    // Fold a coefficient from [-q, 2q-1] into [0, q).
    function automatic logic [11:0] normalize(input logic [15:0] x);
        logic signed [16:0] xs;
        xs = $signed({x[15], x});
        if (xs[16])
            xs = xs + Q_S;
        else if (xs >= Q_S)
            xs = xs - Q_S;
        return 12'(xs);
    endfunction

    // round(x*2^D/q) mod 2^D as floor((x*2^D + (q-1)/2) / q); q is odd so no ties occur.
    // The reciprocal 2^35/q (rounded up) is exact for every numerator below 2^23.
    function automatic logic [D-1:0] compress(input logic [11:0] x);
        logic [NUM_W-1:0]  num;
        logic [PROD_W-1:0] prod;
        num  = (NUM_W'(x) << D) + NUM_W'(HALF_Q);
        prod = PROD_W'(num) * PROD_W'(RECIP);
        return D'(prod >> RECIP_SH);
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else if (set)
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN: begin
                    if (dout_valid && dout_index == DEPTH'(WORDS - 1))
                        state_d = ST_DONE;
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign accept_c  = valid_in && !start && (state_q == ST_RUN) && (in_cnt != DEPTH'(NPAIRS));
    assign exp_idx_c = DEPTH'({in_cnt, 1'b0});

    // Packer: append the S2 pair above the buffered bits; emit a full word or the zero-padded tail.
    always_comb begin
        pair_c   = {s2_c1, s2_c2};
        merged_c = buf_q;
        total_c  = bit_cnt;
        if (s2_v) begin
            merged_c = buf_q | (BUF_W'(pair_c) << bit_cnt);
            total_c  = bit_cnt + CNT_W'(2 * D);
        end
        tail_c    = !s2_v && (pk_cnt == DEPTH'(NPAIRS)) && (bit_cnt != '0);
        emit_c    = tail_c || (total_c >= CNT_W'(32));
        word_c    = merged_c[31:0];
        buf_nxt_c = merged_c;
        cnt_nxt_c = total_c;
        if (emit_c) begin
            buf_nxt_c = merged_c >> 32;
            cnt_nxt_c = tail_c ? '0 : total_c - CNT_W'(32);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt     <= '0;
            pk_cnt     <= '0;
            word_cnt   <= '0;
            s1_v       <= 1'b0;
            s2_v       <= 1'b0;
            s1_x1      <= '0;
            s1_x2      <= '0;
            s2_c1      <= '0;
            s2_c2      <= '0;
            buf_q      <= '0;
            bit_cnt    <= '0;
            dout       <= '0;
            dout_index <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
            done       <= 1'b0;
        end else if (set) begin
            done <= (state_d == ST_DONE);
            if (start) begin
                in_cnt     <= '0;
                pk_cnt     <= '0;
                word_cnt   <= '0;
                s1_v       <= 1'b0;
                s2_v       <= 1'b0;
                buf_q      <= '0;
                bit_cnt    <= '0;
                dout       <= '0;
                dout_index <= '0;
                dout_valid <= 1'b0;
                err        <= 1'b0;
            end else begin
                s1_v <= accept_c;
                if (accept_c) begin
                    s1_x1  <= normalize(comp_din_1);
                    s1_x2  <= normalize(comp_din_2);
                    in_cnt <= in_cnt + DEPTH'(1);
                    if (in_index != exp_idx_c)
                        err <= 1'b1;
                end
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_c1 <= compress(s1_x1);
                    s2_c2 <= compress(s1_x2);
                end
                if (s2_v)
                    pk_cnt <= pk_cnt + DEPTH'(1);
                buf_q      <= buf_nxt_c;
                bit_cnt    <= cnt_nxt_c;
                dout_valid <= emit_c;
                if (emit_c) begin
                    dout       <= word_c;
                    dout_index <= word_cnt;
                    word_cnt   <= word_cnt + DEPTH'(1);
                end
            end
        end
    end

`ifdef POLY_COMPRESS_CHK_EN
    // Rotate-left-by-one XOR over every emitted word.
    always_ff @(posedge clk) begin
        if (reset)
            chk <= '0;
        else if (set) begin
            if (start)
                chk <= '0;
            else if (emit_c)
                chk <= chk ^ {word_c[30:0], word_c[31]};
        end
    end
`else
    assign chk = '0;
`endif

endmodule

// File: tb/tb_poly_compress.sv
// Bench for poly_compress: three configurations (D=10/DEPTH=8, D=4/DEPTH=8, D=5/DEPTH=4) share one stimulus
// stream; a bit-level packing model built from the compression formula supplies every expected word.
module tb_poly_compress;

    localparam int Q = 3329;
    localparam int DS [3]     = '{10, 4, 5};
    localparam int DEPTHS [3] = '{8, 8, 4};

    logic               clk = 1'b0;
    logic               reset, set, start, valid_in;
    logic signed [15:0] din1, din2;
    logic [7:0]         idx;

    logic [31:0] dout_o [3];
    logic [31:0] chk_o [3];
    logic [7:0]  didx_o [3];
    logic [3:0]  didx5;
    logic        dv_o [3];
    logic        err_o [3];
    logic        done_o [3];

    assign didx_o[2] = {4'b0, didx5};

    poly_compress #(.DEPTH(8), .D(10)) u10 (
        .clk(clk), .reset(reset), .set(set), .start(start),
        .comp_din_1(din1), .comp_din_2(din2), .in_index(idx), .valid_in(valid_in),
        .dout(dout_o[0]), .dout_index(didx_o[0]), .dout_valid(dv_o[0]),
        .err(err_o[0]), .chk(chk_o[0]), .done(done_o[0]));

    poly_compress #(.DEPTH(8), .D(4)) u4 (
        .clk(clk), .reset(reset), .set(set), .start(start),
        .comp_din_1(din1), .comp_din_2(din2), .in_index(idx), .valid_in(valid_in),
        .dout(dout_o[1]), .dout_index(didx_o[1]), .dout_valid(dv_o[1]),
        .err(err_o[1]), .chk(chk_o[1]), .done(done_o[1]));

    poly_compress #(.DEPTH(4), .D(5)) u5 (
        .clk(clk), .reset(reset), .set(set), .start(start),
        .comp_din_1(din1), .comp_din_2(din2), .in_index(idx[3:0]), .valid_in(valid_in),
        .dout(dout_o[2]), .dout_index(didx5), .dout_valid(dv_o[2]),
        .err(err_o[2]), .chk(chk_o[2]), .done(done_o[2]));

    always #5 clk = ~clk;

    int   cyc = 0;
    logic set_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        set_q <= set;
    end

    // Word/done recorder: a word counts once, on the active edge that produced it.
    logic [31:0] got_w [3][1024];
    int          got_i [3][1024];
    int          got_c [3][1024];
    int          got_n [3]     = '{0, 0, 0};
    int          done_cyc [3]  = '{-1, -1, -1};
    logic        done_prev [3] = '{1'b0, 1'b0, 1'b0};

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (dv_o[k] && set_q && got_n[k] < 1024) begin
                got_w[k][got_n[k]] = dout_o[k];
                got_i[k][got_n[k]] = int'(didx_o[k]);
                got_c[k][got_n[k]] = cyc;
                got_n[k]++;
            end
            if (done_o[k] && !done_prev[k])
                done_cyc[k] = cyc;
            done_prev[k] = done_o[k];
        end
    end

    int          total = 0;
    int          bad   = 0;
    int          base [3];
    int          t0;
    int          pair_cyc [128];
    int          coef [256];
    logic [31:0] exp_w [3][128];
    int          exp_n [3];
    int          off [3];
    int          snap [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int comp(input int x, input int d);
        int xn;
        xn = x;
        if (xn < 0) xn = xn + Q;
        else if (xn >= Q) xn = xn - Q;
        return ((xn * (1 << d) * 2 + Q) / (2 * Q)) % (1 << d);
    endfunction

    task automatic build_exp(input int k);
        int          d, nbits, pos;
        logic [31:0] wv;
        d        = DS[k];
        nbits    = (1 << DEPTHS[k]) * d;
        exp_n[k] = (nbits + 31) / 32;
        for (int w = 0; w < exp_n[k]; w++) begin
            wv = '0;
            for (int b = 0; b < 32; b++) begin
                pos = 32 * w + b;
                if (pos < nbits)
                    wv[b] = ((comp(coef[pos / d], d) >> (pos % d)) & 1) != 0;
            end
            exp_w[k][w] = wv;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 256; i++)
            coef[i] = int'($urandom_range(3 * Q - 1, 0)) - Q;
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < 256; i++)
            coef[i] = v;
    endtask

    task automatic do_start(input logic junk);
        start    = 1'b1;
        valid_in = junk;
        din1     = 16'sd77;
        din2     = 16'sd5;
        idx      = 8'd0;
        @(posedge clk); #1;
        start    = 1'b0;
        valid_in = 1'b0;
        for (int k = 0; k < 3; k++) base[k] = got_n[k];
        t0 = cyc;
    endtask

    task automatic drive_stream(input bit skip, input int freeze_at, input int stop_after);
        for (int p = 0; p < 128; p++) begin
            if (p == stop_after) break;
            if (p == freeze_at) begin
                set      = 1'b0;
                valid_in = 1'b0;
                repeat (5) @(posedge clk);
                #1 set = 1'b1;
            end
            valid_in    = 1'b1;
            din1        = 16'(coef[2 * p + 1]);
            din2        = 16'(coef[2 * p]);
            idx         = 8'((skip && p >= 2) ? 2 * p + 2 : 2 * p);
            pair_cyc[p] = cyc;
            if (skip && p == 2)
                check("err_before_skip", 32'(err_o[0]), 32'd0);
            if (skip && p == 3)
                for (int k = 0; k < 3; k++)
                    check($sformatf("err_after_skip_%0d", k), 32'(err_o[k]), 32'd1);
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 600; i++) begin
            if (done_o[0] && done_o[1] && done_o[2]) break;
            @(posedge clk); #1;
        end
        check("done_timeout", {29'd0, done_o[0], done_o[1], done_o[2]}, 32'd7);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_run(input bit lat);
        int          n, d, nbits, last, ec;
        logic [31:0] cm;
        for (int k = 0; k < 3; k++) begin
            build_exp(k);
            n     = got_n[k] - base[k];
            d     = DS[k];
            nbits = (1 << DEPTHS[k]) * d;
            check($sformatf("count_%0d", k), 32'(n), 32'(exp_n[k]));
            cm = '0;
            for (int w = 0; w < exp_n[k]; w++)
                cm = cm ^ {exp_w[k][w][30:0], exp_w[k][w][31]};
            for (int w = 0; w < n && w < exp_n[k]; w++) begin
                check($sformatf("word_%0d_%0d", k, w), got_w[k][base[k] + w], exp_w[k][w]);
                check($sformatf("index_%0d_%0d", k, w), 32'(got_i[k][base[k] + w]), 32'(w));
                if (lat) begin
                    if (w == exp_n[k] - 1 && nbits % 32 != 0)
                        ec = pair_cyc[(1 << DEPTHS[k]) / 2 - 1] + 4;
                    else
                        ec = pair_cyc[((32 * w + 31) / d) / 2] + 3;
                    check($sformatf("latency_%0d_%0d", k, w), 32'(got_c[k][base[k] + w]), 32'(ec));
                end
            end
            if (n > 0) begin
                last = base[k] + n - 1;
                check($sformatf("done_after_last_%0d", k), 32'(done_cyc[k]), 32'(got_c[k][last] + 1));
            end
`ifdef POLY_COMPRESS_CHK_EN
            check($sformatf("chk_%0d", k), chk_o[k], cm);
`else
            check($sformatf("chk_%0d", k), chk_o[k], 32'd0);
`endif
        end
    endtask

    initial begin
        reset = 1'b1; set = 1'b1; start = 1'b0; valid_in = 1'b0;
        din1 = '0; din2 = '0; idx = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_dout_%0d", k), dout_o[k], 32'd0);
            check($sformatf("rst_didx_%0d", k), 32'(didx_o[k]), 32'd0);
            check($sformatf("rst_flags_%0d", k), {28'd0, dv_o[k], err_o[k], done_o[k], 1'b0}, 32'd0);
            check($sformatf("rst_chk_%0d", k), chk_o[k], 32'd0);
        end

        // valid_in while IDLE is ignored and raises no error
        valid_in = 1'b1; idx = 8'd6; din1 = 16'sd100; din2 = 16'sd200;
        repeat (3) @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("idle_words_%0d", k), 32'(got_n[k]), 32'd0);
            check($sformatf("idle_err_%0d", k), 32'(err_o[k]), 32'd0);
        end

        // Poly A: directed leading coefficients, random remainder
        fill_rand();
        coef[0] = 0; coef[1] = 1665; coef[2] = 3328; coef[3] = -1; coef[4] = 832;
        do_start(1'b0);
        drive_stream(1'b0, -1, -1);
        wait_done();
        check_run(1'b1);
        check("a_word0_d10", got_w[0][base[0]], 32'h0008_0000);
        check("a_coef4_d10", (got_w[0][base[0] + 1] >> 8) & 32'h3ff, 32'd256);

        // valid_in while DONE is ignored
        for (int k = 0; k < 3; k++) snap[k] = got_n[k];
        valid_in = 1'b1; idx = 8'd2;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("done_ignore_words_%0d", k), 32'(got_n[k]), 32'(snap[k]));
            check($sformatf("done_ignore_flags_%0d", k), {30'd0, err_o[k], done_o[k]}, 32'd1);
        end

        // Poly B: all 1665
        fill_const(1665);
        do_start(1'b0);
        drive_stream(1'b0, -1, -1);
        wait_done();
        check_run(1'b1);
        check("b_word0_d10", got_w[0][base[0]], 32'h2008_0200);
        for (int w = 0; w < 32; w++)
            check($sformatf("b_d4_word_%0d", w), got_w[1][base[1] + w], 32'h8888_8888);
        check("b_d5_tail_hi", got_w[2][base[2] + 2] >> 16, 32'd0);

        // Poly C: clean run, then same data with a 5-cycle set=0 freeze
        fill_rand();
        do_start(1'b0);
        drive_stream(1'b0, -1, -1);
        wait_done();
        check_run(1'b1);
        for (int k = 0; k < 2; k++) off[k] = done_cyc[k] - t0;
        do_start(1'b0);
        drive_stream(1'b0, 40, -1);
        wait_done();
        check_run(1'b0);
        for (int k = 0; k < 2; k++)
            check($sformatf("freeze_delay_%0d", k), 32'(done_cyc[k] - t0), 32'(off[k] + 5));

        // Skipped index: error is sticky, data still packed
        do_start(1'b0);
        drive_stream(1'b1, -1, -1);
        wait_done();
        check_run(1'b1);
        for (int k = 0; k < 3; k++)
            check($sformatf("skip_err_sticky_%0d", k), 32'(err_o[k]), 32'd1);

        // start mid-stream (with a dropped same-cycle pair), then a fresh polynomial
        fill_rand();
        do_start(1'b0);
        drive_stream(1'b0, -1, 10);
        fill_rand();
        do_start(1'b1);
        drive_stream(1'b0, -1, -1);
        wait_done();
        check_run(1'b1);
        for (int k = 0; k < 3; k++)
            check($sformatf("restart_err_%0d", k), 32'(err_o[k]), 32'd0);

        // reset mid-stream after an error
        do_start(1'b0);
        drive_stream(1'b1, -1, 20);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midrst_dout_%0d", k), dout_o[k], 32'd0);
            check($sformatf("midrst_didx_%0d", k), 32'(didx_o[k]), 32'd0);
            check($sformatf("midrst_flags_%0d", k), {29'd0, dv_o[k], err_o[k], done_o[k]}, 32'd0);
            check($sformatf("midrst_chk_%0d", k), chk_o[k], 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
